// File: rtl/alu_rr_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters.
// The ALU result is captured into a single-entry, ID-tagged response buffer.
module alu_rr_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,

  output logic [2:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,

  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
);

  logic last_grant;
  logic gnt_valid;
  logic gnt_id;
  logic can_accept;
  logic hs0;
  logic hs1;

  // Tie goes to whichever requester was not served by the last handshake.
  always_comb begin
    gnt_valid = req0_valid | req1_valid;
    gnt_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_id = ~last_grant;
    end else if (req1_valid) begin
      gnt_id = 1'b1;
    end
  end

  // The buffer may be refilled in the same cycle it is drained.
  assign can_accept = ~rsp_valid | rsp_ready;

  assign req0_ready = can_accept & gnt_valid & ~gnt_id;
  assign req1_ready = can_accept & gnt_valid &  gnt_id;

  assign hs0 = req0_valid & req0_ready;
  assign hs1 = req1_valid & req1_ready;

  // Operands follow the grant even under backpressure; idle drives zeros.
  always_comb begin
    alu_ctrl = '0;
    alu_a    = '0;
    alu_b    = '0;
    if (gnt_valid) begin
      if (gnt_id) begin
        alu_ctrl = req1_op;
        alu_a    = req1_a;
        alu_b    = req1_b;
      end else begin
        alu_ctrl = req0_op;
        alu_a    = req0_a;
        alu_b    = req0_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      last_grant <= 1'b1;
    end else if (hs0 || hs1) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= hs1;
      rsp_data   <= alu_out;
      last_grant <= hs1;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

  // Saturating grant counters; clear wins over a same-cycle handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (cnt_clr) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (hs0 && (grant_cnt0 != {CNT_W{1'b1}})) begin
        grant_cnt0 <= grant_cnt0 + 1'b1;
      end
      if (hs1 && (grant_cnt1 != {CNT_W{1'b1}})) begin
        grant_cnt1 <= grant_cnt1 + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a behavioural ALU attached to the
// alu_ctrl/alu_a/alu_b outputs; expected values are hand-computed constants.
module tb_alu_rr_arbiter;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst_n;
  logic              req0_valid, req0_ready;
  logic [2:0]        req0_op;
  logic [DATA_W-1:0] req0_a, req0_b;
  logic              req1_valid, req1_ready;
  logic [2:0]        req1_op;
  logic [DATA_W-1:0] req1_a, req1_b;
  logic [2:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_a, alu_b, alu_out;
  logic              rsp_valid, rsp_ready, rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              cnt_clr;
  logic [CNT_W-1:0]  grant_cnt0, grant_cnt1;

  int n_vec = 0;
  int n_err = 0;

  alu_rr_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .cnt_clr(cnt_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  // Reference ALU
  always_comb begin
    alu_out = '0;
    case (alu_ctrl)
      3'd0: alu_out = alu_a + alu_b;
      3'd1: alu_out = {31'd0, (alu_a < alu_b)};
      3'd2: alu_out = alu_a << alu_b[4:0];
      3'd3: alu_out = alu_a >> alu_b[4:0];
      3'd4: alu_out = $signed(alu_a) >>> alu_b[4:0];
      3'd5: alu_out = alu_a & alu_b;
      3'd6: alu_out = alu_a | alu_b;
      3'd7: alu_out = alu_a ^ alu_b;
      default: alu_out = '0;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; cnt_clr = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = 3'd0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = 3'd0; req1_a = '0; req1_b = '0;

    // 1. asynchronous reset, checked before any clock edge
    #3 rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data",  rsp_data,  0);
    chk("rst_rsp_id",    rsp_id,    0);
    chk("rst_cnt0",      grant_cnt0, 0);
    chk("rst_cnt1",      grant_cnt1, 0);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("idle_alu_ctrl", alu_ctrl, 0);
    chk("idle_alu_a",    alu_a,    0);
    chk("idle_alu_b",    alu_b,    0);
    chk("idle_ready0",   req0_ready, 0);

    // 2. single op 5 + 7
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'd5; req0_b = 32'd7; rsp_ready = 1'b1;
    #1;
    chk("single_ready0", req0_ready, 1);
    chk("single_ready1", req1_ready, 0);
    chk("single_alu_a",  alu_a, 5);
    step();
    req0_valid = 1'b0;
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_id",    rsp_id, 0);
    chk("single_rsp_data",  rsp_data, 32'd12);
    chk("single_cnt0",      grant_cnt0, 1);

    // 3. round-robin from a fresh reset (last_grant=1 -> req0 first)
    rst_n = 1'b0; #1; rst_n = 1'b1; #1;
    req0_valid = 1'b1; req0_op = 3'd7; req0_a = 32'h0000F0F0; req0_b = 32'h0000FFFF;
    req1_valid = 1'b1; req1_op = 3'd2; req1_a = 32'd1;         req1_b = 32'd4;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready0", req0_ready, (i % 2 == 0) ? 1 : 0);
      chk("rr_ready1", req1_ready, (i % 2 == 1) ? 1 : 0);
      step();
      chk("rr_rsp_valid", rsp_valid, 1);
      chk("rr_rsp_id",    rsp_id, (i % 2 == 1) ? 1 : 0);
      chk("rr_rsp_data",  rsp_data, (i % 2 == 0) ? 32'h00000F0F : 32'h00000010);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_cnt0", grant_cnt0, 2);
    chk("rr_cnt1", grant_cnt1, 2);
    step();
    chk("drain_rsp_valid", rsp_valid, 0);
    chk("drain_rsp_data",  rsp_data, 32'h00000010);

    // 4. backpressure, then drain+accept in one cycle
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'd5; req0_b = 32'd7;
    step();
    req0_valid = 1'b0; rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_op = 3'd6; req1_a = 32'h3; req1_b = 32'hC;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready1",   req1_ready, 0);
      chk("bp_alu_ctrl", alu_ctrl, 6);
      step();
      chk("bp_rsp_data", rsp_data, 32'd12);
      chk("bp_rsp_id",   rsp_id, 0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready1", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_rsp_data",  rsp_data, 32'h0000000F);
    chk("bp_rsp_id",    rsp_id, 1);
    step();

    // 5. counter saturation and clear priority
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_cnt0", grant_cnt0, 0);
    chk("clr_cnt1", grant_cnt1, 0);
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'd1; req0_b = 32'd1;
    repeat (65534) step();
    chk("sat_cnt0_fffe", grant_cnt0, 32'hFFFE);
    step();
    chk("sat_cnt0_ffff", grant_cnt0, 32'hFFFF);
    repeat (4465) step();
    chk("sat_cnt0_hold", grant_cnt0, 32'hFFFF);
    chk("sat_cnt1",      grant_cnt1, 0);
    cnt_clr = 1'b1;
    #1;
    chk("clr_hs_ready0", req0_ready, 1);
    step();
    cnt_clr = 1'b0;
    chk("clr_hs_cnt0", grant_cnt0, 0);
    chk("clr_hs_cnt1", grant_cnt1, 0);
    step();
    req0_valid = 1'b0;
    chk("post_clr_cnt0", grant_cnt0, 1);
    step();

    // 6. reset mid-stream discards buffered response and restores priority
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'd5; req0_b = 32'd7;
    step();
    req0_valid = 1'b0;
    chk("mid_rsp_valid_pre", rsp_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_rsp_data",  rsp_data, 0);
    step();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd5; req0_a = 32'hFF00FF00; req0_b = 32'h0FF00FF0;
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = 32'd1;         req1_b = 32'd2;
    #1;
    chk("mid_ready0", req0_ready, 1);
    chk("mid_ready1", req1_ready, 0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("mid_rsp_id",   rsp_id, 0);
    chk("mid_rsp_data2", rsp_data, 32'h0F000F00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
